// File: rtl/bp_be_dcache_wbuf.sv
// bp_be_dcache_wbuf
// Two-entry FIFO store write buffer that sits between the dcache tag-check
// stage and the data memory. It provides same-doubleword store-to-load
// forwarding and a set-index snoop for the coherence engine.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-low reset
//   v_i, paddr_i, data_i,   store entry from tag-check (lane-aligned data,
//   mask_i, way_id_i        byte mask, hit way)
//   ready_o                 an entry can be accepted this cycle
//   v_o, paddr_o, data_o,   head entry toward data memory
//   mask_o, way_id_o
//   yumi_i                  data memory consumed the head this cycle
//   bypass_v_i,             load forwarding request and address
//   bypass_paddr_i
//   bypass_data_o,          merged forwarded bytes and the lanes supplied
//   bypass_mask_o
//   snoop_index_i,          set index targeted by the LCE and whether any
//   snoop_match_o           valid entry falls in that set
//   empty_o                 no valid entries
module bp_be_dcache_wbuf #(
    parameter int paddr_width_p = 56,
    parameter int data_width_p  = 64,
    parameter int ways_p        = 8,
    parameter int sets_p        = 64,
    localparam int mask_width_lp   = data_width_p / 8,
    localparam int way_id_width_lp = $clog2(ways_p),
    localparam int index_width_lp  = $clog2(sets_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       v_i,
    input  logic [paddr_width_p-1:0]   paddr_i,
    input  logic [data_width_p-1:0]    data_i,
    input  logic [mask_width_lp-1:0]   mask_i,
    input  logic [way_id_width_lp-1:0] way_id_i,
    output logic                       ready_o,

    output logic                       v_o,
    output logic [paddr_width_p-1:0]   paddr_o,
    output logic [data_width_p-1:0]    data_o,
    output logic [mask_width_lp-1:0]   mask_o,
    output logic [way_id_width_lp-1:0] way_id_o,
    input  logic                       yumi_i,

    input  logic                       bypass_v_i,
    input  logic [paddr_width_p-1:0]   bypass_paddr_i,
    output logic [data_width_p-1:0]    bypass_data_o,
    output logic [mask_width_lp-1:0]   bypass_mask_o,

    input  logic [index_width_lp-1:0]  snoop_index_i,
    output logic                       snoop_match_o,

    output logic                       empty_o
);

    localparam int block_offset_lp = 6;

    logic [paddr_width_p-1:0]   paddr_r  [2];
    logic [data_width_p-1:0]    data_r   [2];
    logic [mask_width_lp-1:0]   mask_r   [2];
    logic [way_id_width_lp-1:0] way_id_r [2];

    logic [1:0] valid_r;
    logic [1:0] count_r;
    logic       head_r;
    logic       tail_r;

    logic enq;
    logic deq;
    logic newer;
    logic older_hit;
    logic newer_hit;

    // Only the doubleword address takes part in forwarding; the byte offset
    // is already encoded in the lane masks.
    logic unused_bypass_offset;
    assign unused_bypass_offset = ^bypass_paddr_i[2:0];

    // ready_o looks only at the count, so a full buffer refuses a store even
    // when the head is retiring in the same cycle.
    assign ready_o = (count_r < 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign empty_o = (count_r == 2'd0);

    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    assign paddr_o  = paddr_r[head_r];
    assign data_o   = data_r[head_r];
    assign mask_o   = mask_r[head_r];
    assign way_id_o = way_id_r[head_r];

    // Control state. A retiring slot clears its valid bit so the non-head
    // slot is only valid when two entries are held.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_r <= 2'd0;
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            valid_r <= 2'b00;
        end else begin
            if (enq) begin
                tail_r          <= ~tail_r;
                valid_r[tail_r] <= 1'b1;
            end
            if (deq) begin
                head_r          <= ~head_r;
                valid_r[head_r] <= 1'b0;
            end
            count_r <= count_r + 2'(enq) - 2'(deq);
        end
    end

    // Payload storage carries no reset; valid bits qualify every use.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            paddr_r[tail_r]  <= paddr_i;
            data_r[tail_r]   <= data_i;
            mask_r[tail_r]   <= mask_i;
            way_id_r[tail_r] <= way_id_i;
        end
    end

    assign newer = ~head_r;

    assign older_hit = bypass_v_i & valid_r[head_r]
                     & (paddr_r[head_r][paddr_width_p-1:3] == bypass_paddr_i[paddr_width_p-1:3]);
    assign newer_hit = bypass_v_i & valid_r[newer]
                     & (paddr_r[newer][paddr_width_p-1:3] == bypass_paddr_i[paddr_width_p-1:3]);

    // Forwarding merge: the newer store wins any lane both entries write.
    // A store being enqueued this cycle is not yet in the registers, so it
    // never forwards; a retiring head is still valid and still forwards.
    always_comb begin
        bypass_data_o = '0;
        bypass_mask_o = '0;
        for (int l = 0; l < mask_width_lp; l++) begin
            if (newer_hit && mask_r[newer][l]) begin
                bypass_data_o[l*8 +: 8] = data_r[newer][l*8 +: 8];
                bypass_mask_o[l]        = 1'b1;
            end else if (older_hit && mask_r[head_r][l]) begin
                bypass_data_o[l*8 +: 8] = data_r[head_r][l*8 +: 8];
                bypass_mask_o[l]        = 1'b1;
            end
        end
    end

    // Snoop compares the set index field of every valid entry.
    always_comb begin
        snoop_match_o = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (valid_r[i]
                && (paddr_r[i][block_offset_lp +: index_width_lp] == snoop_index_i)) begin
                snoop_match_o = 1'b1;
            end
        end
    end

    // Protocol checks: stores offered to a full buffer are dropped, and a
    // yumi with nothing at the head is ignored. Both are flagged in sim.
    store_dropped_when_full: assert property (
        @(posedge clk_i) disable iff (!reset_i) !(v_i && !ready_o))
        else $warning("wbuf: store dropped, buffer full");

    yumi_without_valid: assert property (
        @(posedge clk_i) disable iff (!reset_i) !(yumi_i && !v_o))
        else $warning("wbuf: yumi ignored, buffer empty");

endmodule

// File: tb/tb_bp_be_dcache_wbuf.sv
// tb_bp_be_dcache_wbuf
// Self-checking bench for bp_be_dcache_wbuf. A queue-based model holds the
// buffered stores in age order; every cycle the DUT outputs are compared to
// what that queue implies. Directed sequences pin the model with literal
// expectations, then a randomized phase exercises the buffer at length.
module tb_bp_be_dcache_wbuf;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic [55:0] paddr_i = '0;
    logic [63:0] data_i = '0;
    logic [7:0]  mask_i = '0;
    logic [2:0]  way_id_i = '0;
    logic        ready_o;
    logic        v_o;
    logic [55:0] paddr_o;
    logic [63:0] data_o;
    logic [7:0]  mask_o;
    logic [2:0]  way_id_o;
    logic        yumi_i = 1'b0;
    logic        bypass_v_i = 1'b0;
    logic [55:0] bypass_paddr_i = '0;
    logic [63:0] bypass_data_o;
    logic [7:0]  bypass_mask_o;
    logic [5:0]  snoop_index_i = '0;
    logic        snoop_match_o;
    logic        empty_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [55:0] paddr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [2:0]  way;
    } ent_t;

    ent_t model_q[$];

    bp_be_dcache_wbuf dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .paddr_i        (paddr_i),
        .data_i         (data_i),
        .mask_i         (mask_i),
        .way_id_i       (way_id_i),
        .ready_o        (ready_o),
        .v_o            (v_o),
        .paddr_o        (paddr_o),
        .data_o         (data_o),
        .mask_o         (mask_o),
        .way_id_o       (way_id_o),
        .yumi_i         (yumi_i),
        .bypass_v_i     (bypass_v_i),
        .bypass_paddr_i (bypass_paddr_i),
        .bypass_data_o  (bypass_data_o),
        .bypass_mask_o  (bypass_mask_o),
        .snoop_index_i  (snoop_index_i),
        .snoop_match_o  (snoop_match_o),
        .empty_o        (empty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=still_running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Everything the outputs must show follows from the age-ordered queue.
    task automatic checkOutput();
        logic [63:0] exp_data;
        logic [7:0]  exp_mask;
        logic        exp_snoop;
        exp_data  = '0;
        exp_mask  = '0;
        exp_snoop = 1'b0;
        if (bypass_v_i) begin
            foreach (model_q[i]) begin
                if (model_q[i].paddr[55:3] == bypass_paddr_i[55:3]) begin
                    for (int l = 0; l < 8; l++)
                        if (model_q[i].mask[l]) exp_data[l*8 +: 8] = model_q[i].data[l*8 +: 8];
                    exp_mask |= model_q[i].mask;
                end
            end
        end
        foreach (model_q[i])
            if (model_q[i].paddr[11:6] == snoop_index_i) exp_snoop = 1'b1;
        checkValue("ready_o", 64'(ready_o), 64'(model_q.size() < 2));
        checkValue("v_o", 64'(v_o), 64'(model_q.size() != 0));
        checkValue("empty_o", 64'(empty_o), 64'(model_q.size() == 0));
        if (model_q.size() != 0) begin
            checkValue("paddr_o", 64'(paddr_o), 64'(model_q[0].paddr));
            checkValue("data_o", data_o, model_q[0].data);
            checkValue("mask_o", 64'(mask_o), 64'(model_q[0].mask));
            checkValue("way_id_o", 64'(way_id_o), 64'(model_q[0].way));
        end
        checkValue("bypass_data_o", bypass_data_o, exp_data);
        checkValue("bypass_mask_o", 64'(bypass_mask_o), 64'(exp_mask));
        checkValue("snoop_match_o", 64'(snoop_match_o), 64'(exp_snoop));
    endtask

    // Drive one cycle's inputs on the falling edge and check the settled outputs.
    task automatic applyStimulus(input logic v, input logic [55:0] pa, input logic [63:0] d,
                                 input logic [7:0] m, input logic [2:0] w, input logic y,
                                 input logic bv, input logic [55:0] bpa, input logic [5:0] sn);
        @(negedge clk_i);
        v_i = v; paddr_i = pa; data_i = d; mask_i = m; way_id_i = w;
        yumi_i = y; bypass_v_i = bv; bypass_paddr_i = bpa; snoop_index_i = sn;
        #1;
        checkOutput();
    endtask

    task automatic hold(input logic y, input logic bv, input logic [55:0] bpa, input logic [5:0] sn);
        applyStimulus(1'b0, '0, '0, '0, '0, y, bv, bpa, sn);
    endtask

    // Advance the model across a rising edge with the inputs held there.
    task automatic commitEdge();
        logic acc;
        logic ret;
        @(posedge clk_i);
        if (reset_i) begin
            acc = v_i && (model_q.size() < 2);
            ret = yumi_i && (model_q.size() > 0);
            if (ret) void'(model_q.pop_front());
            if (acc) model_q.push_back('{paddr: paddr_i, data: data_i, mask: mask_i, way: way_id_i});
        end
    endtask

    // Asynchronous reset pulse wholly between two rising edges.
    task automatic resetPulse();
        reset_i = 1'b0;
        #2;
        model_q.delete();
        checkValue("rst v_o", 64'(v_o), 64'd0);
        checkValue("rst empty_o", 64'(empty_o), 64'd1);
        checkValue("rst ready_o", 64'(ready_o), 64'd1);
        checkValue("rst snoop_match_o", 64'(snoop_match_o), 64'd0);
        checkValue("rst bypass_mask_o", 64'(bypass_mask_o), 64'd0);
        #1;
        reset_i = 1'b1;
    endtask

    function automatic logic [55:0] randAddr();
        return 56'h2000 + (56'($urandom_range(0, 3)) << 6)
             + (56'($urandom_range(0, 3)) << 3) + 56'($urandom_range(0, 7));
    endfunction

    localparam logic [63:0] DATA_A  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] DATA_B  = 64'h2222_2222_2222_2222;
    localparam logic [63:0] DATA_C  = 64'h3333_3333_3333_3333;
    localparam logic [63:0] DATA_AA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] DATA_BB = 64'hBBBB_BBBB_BBBB_BBBB;

    initial begin
        // Power-on reset, with a forwarding request present.
        #1 reset_i = 1'b0;
        bypass_v_i = 1'b1;
        #2;
        checkValue("por ready_o", 64'(ready_o), 64'd1);
        checkValue("por v_o", 64'(v_o), 64'd0);
        checkValue("por empty_o", 64'(empty_o), 64'd1);
        checkValue("por snoop_match_o", 64'(snoop_match_o), 64'd0);
        checkValue("por bypass_mask_o", 64'(bypass_mask_o), 64'd0);

        // Store A is presented while still in reset; reset releases before the
        // next rising edge, which must accept it.
        applyStimulus(1'b1, 56'h1000, DATA_A, 8'hFF, 3'd2, 1'b0, 1'b0, '0, '0);
        #1 reset_i = 1'b1;
        commitEdge();
        hold(1'b0, 1'b0, '0, '0);
        checkValue("A v_o", 64'(v_o), 64'd1);
        checkValue("A paddr_o", 64'(paddr_o), 64'h1000);
        checkValue("A data_o", data_o, DATA_A);
        checkValue("A mask_o", 64'(mask_o), 64'hFF);
        checkValue("A ready_o", 64'(ready_o), 64'd1);
        checkValue("A empty_o", 64'(empty_o), 64'd0);

        // Fill, drop a third store, then drain in order.
        applyStimulus(1'b1, 56'h1008, DATA_B, 8'hF0, 3'd5, 1'b0, 1'b0, '0, '0);
        commitEdge();
        hold(1'b0, 1'b0, '0, '0);
        checkValue("full ready_o", 64'(ready_o), 64'd0);
        applyStimulus(1'b1, 56'h1010, DATA_C, 8'h0F, 3'd1, 1'b0, 1'b0, '0, '0);
        commitEdge();
        hold(1'b1, 1'b0, '0, '0);
        checkValue("drain1 paddr_o", 64'(paddr_o), 64'h1000);
        commitEdge();
        hold(1'b1, 1'b0, '0, '0);
        checkValue("drain2 paddr_o", 64'(paddr_o), 64'h1008);
        checkValue("drain2 way_id_o", 64'(way_id_o), 64'd5);
        commitEdge();
        hold(1'b0, 1'b0, '0, '0);
        checkValue("drained v_o", 64'(v_o), 64'd0);

        // Full buffer with store and yumi together: store dropped, A retired.
        applyStimulus(1'b1, 56'h1000, DATA_A, 8'hFF, 3'd2, 1'b0, 1'b0, '0, '0);
        commitEdge();
        applyStimulus(1'b1, 56'h1008, DATA_B, 8'hF0, 3'd5, 1'b0, 1'b0, '0, '0);
        commitEdge();
        applyStimulus(1'b1, 56'h1010, DATA_C, 8'h0F, 3'd1, 1'b1, 1'b0, '0, '0);
        commitEdge();
        hold(1'b0, 1'b0, '0, '0);
        checkValue("simul paddr_o", 64'(paddr_o), 64'h1008);
        checkValue("simul ready_o", 64'(ready_o), 64'd1);
        checkValue("simul v_o", 64'(v_o), 64'd1);
        hold(1'b1, 1'b0, '0, '0);
        commitEdge();

        // Forwarding merge; a store entering this cycle does not forward.
        applyStimulus(1'b1, 56'h2000, DATA_AA, 8'h0F, 3'd0, 1'b0, 1'b1, 56'h2000, '0);
        checkValue("enq no bypass", 64'(bypass_mask_o), 64'd0);
        commitEdge();
        applyStimulus(1'b1, 56'h2004, DATA_BB, 8'h3C, 3'd0, 1'b0, 1'b1, 56'h2000, '0);
        commitEdge();
        hold(1'b0, 1'b1, 56'h2000, '0);
        checkValue("merge mask", 64'(bypass_mask_o), 64'h3F);
        checkValue("merge data", bypass_data_o, 64'h0000_BBBB_BBBB_AAAA);
        hold(1'b0, 1'b0, 56'h2000, '0);
        checkValue("no req mask", 64'(bypass_mask_o), 64'd0);
        checkValue("no req data", bypass_data_o, 64'd0);
        hold(1'b1, 1'b1, 56'h2000, '0);
        checkValue("retiring mask", 64'(bypass_mask_o), 64'h3F);
        commitEdge();
        hold(1'b0, 1'b1, 56'h2000, '0);
        checkValue("after retire data", bypass_data_o, 64'h0000_BBBB_BBBB_0000);
        hold(1'b1, 1'b0, '0, '0);
        commitEdge();

        // Snoop on set index 5.
        applyStimulus(1'b1, 56'h140, DATA_C, 8'h01, 3'd3, 1'b0, 1'b0, '0, 6'd5);
        checkValue("snoop pre", 64'(snoop_match_o), 64'd0);
        commitEdge();
        hold(1'b0, 1'b0, '0, 6'd5);
        checkValue("snoop hit", 64'(snoop_match_o), 64'd1);
        hold(1'b0, 1'b0, '0, 6'd4);
        checkValue("snoop other", 64'(snoop_match_o), 64'd0);
        hold(1'b1, 1'b0, '0, 6'd5);
        commitEdge();
        hold(1'b0, 1'b0, '0, 6'd5);
        checkValue("snoop gone", 64'(snoop_match_o), 64'd0);

        // Mid-operation reset discards both held stores.
        applyStimulus(1'b1, 56'h1000, DATA_A, 8'hFF, 3'd2, 1'b0, 1'b0, '0, '0);
        commitEdge();
        applyStimulus(1'b1, 56'h1008, DATA_B, 8'hF0, 3'd5, 1'b0, 1'b0, '0, '0);
        commitEdge();
        hold(1'b0, 1'b0, '0, '0);
        resetPulse();
        commitEdge();
        hold(1'b0, 1'b0, '0, '0);
        checkValue("post rst v_o", 64'(v_o), 64'd0);
        checkValue("post rst empty_o", 64'(empty_o), 64'd1);
        commitEdge();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 99) < 60, randAddr(), {$urandom, $urandom},
                          8'($urandom), 3'($urandom), $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 75, randAddr(), 6'($urandom_range(0, 4)));
            if ($urandom_range(0, 99) == 0) resetPulse();
            commitEdge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_be_dcache_wbuf.md
BP_BE_DCACHE_WBUF -- requirements
Module: bp_be_dcache_wbuf

Interface
REQ-001 The block SHALL have parameter paddr_width_p, default 56, meaning physical address width in bits.
REQ-002 The block SHALL have parameter data_width_p, default 64, meaning store data width in bits; data_width_p/8 byte lanes.
REQ-003 The block SHALL have parameter ways_p, default 8, meaning number of dcache ways; way_id width is log2(ways_p).
REQ-004 The block SHALL have parameter sets_p, default 64, meaning number of dcache sets; index width is log2(sets_p), taken from paddr bits just above the block offset (block offset = 6 bits).
REQ-005 The block SHALL have these ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- v_i  in  1  store entry valid from the dcache tag-check stage.
- paddr_i  in  paddr_width_p  store physical address.
- data_i  in  data_width_p  store data, already lane-aligned.
- mask_i  in  data_width_p/8  byte write mask.
- way_id_i  in  log2(ways_p)  hit way.
- ready_o  out  1  buffer can accept an entry this cycle.
- v_o  out  1  head entry valid toward data memory.
- paddr_o, data_o, mask_o, way_id_o  out  as inputs  head entry fields.
- yumi_i  in  1  data memory consumed head this cycle.
- bypass_v_i  in  1  load requests forwarding.
- bypass_paddr_i  in  paddr_width_p  load address.
- bypass_data_o  out  data_width_p  merged forwarded bytes.
- bypass_mask_o  out  data_width_p/8  lanes supplied by the buffer.
- snoop_index_i  in  log2(sets_p)  LCE-targeted set index.
- snoop_match_o  out  1  some valid entry targets snoop_index_i.
- empty_o  out  1  no valid entries.

Function
REQ-006 The buffer SHALL hold exactly 2 entries in FIFO order, with a count register ranging from 0 to 2.
REQ-007 ready_o SHALL equal (count < 2) and SHALL NOT depend combinationally on yumi_i.
REQ-008 On a cycle with v_i=1 and ready_o=1, the entry SHALL be written at the tail.
REQ-009 On a cycle with v_i=1 and ready_o=0, the entry SHALL be dropped, state SHALL be unchanged, and a simulation assertion SHALL fire.
REQ-010 v_o SHALL equal (count != 0), and the head fields SHALL come directly from registers.
REQ-011 On a cycle with yumi_i=1 and v_o=1, the head SHALL be retired; yumi_i=1 with v_o=0 SHALL be ignored and a simulation assertion SHALL fire.
REQ-012 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-013 When count=0, an entry enqueued in cycle N SHALL appear on v_o in cycle N+1; there SHALL be no same-cycle flow-through.
REQ-014 Head and tail pointers SHALL be 1 bit each and SHALL wrap from 1 to 0.
REQ-015 Bypass SHALL be combinational; a valid entry matches when its paddr bits [paddr_width_p-1:3] equal bypass_paddr_i[paddr_width_p-1:3].
REQ-016 Merging SHALL apply the older matching entry first, then the newer, so the newer entry wins on overlapping lanes; bypass_mask_o SHALL be the OR of matching masks.
REQ-017 Lanes with bypass_mask_o=0 SHALL drive 0 on bypass_data_o.
REQ-018 When bypass_v_i=0, bypass_data_o and bypass_mask_o SHALL be 0.
REQ-019 An entry being enqueued in the current cycle SHALL NOT participate in bypass.
REQ-020 An entry retiring in the current cycle SHALL still participate in bypass.
REQ-021 snoop_match_o SHALL be the combinational OR, over valid entries, of (entry index == snoop_index_i).
REQ-022 empty_o SHALL equal (count == 0).

Reset
REQ-023 While reset_i=0, count SHALL be 0, both pointers SHALL be 0, and all valid bits SHALL be cleared, independent of clk_i.
REQ-024 While reset_i=0, outputs SHALL be: ready_o=1, v_o=0, empty_o=1, snoop_match_o=0, bypass_mask_o=0.
REQ-025 Entry data registers need not be reset.
REQ-026 Assertion of reset mid-operation SHALL discard all pending entries.
REQ-027 The first enqueue SHALL be accepted on the first clock edge after reset_i rises.

Verification
REQ-028 Enqueue A (paddr 0x1000, data 0x11..11, mask 0xFF) with yumi_i=0 -> v_o=1 next cycle with A's fields; ready_o=1; empty_o=0.
REQ-029 Enqueue A then B with yumi_i=0 -> ready_o=0; a third v_i is dropped and the assertion fires; with yumi_i=1 for two cycles, v_o shows A then B, then v_o=0.
REQ-030 Full buffer with v_i=1 and yumi_i=1 in the same cycle -> C dropped, A retired, count=1.
REQ-031 Entries A at 0x2000 (data 0xAAAA..., mask 0x0F) and B at 0x2004 (data 0xBBBB..., mask 0x3C), bypass_paddr 0x2000 -> mask 0x3F; lanes 0-1 come from A, lanes 2-5 come from B; data zero elsewhere.
REQ-032 Entry at index 5 with snoop_index_i=5 -> snoop_match_o=1; after the entry retires, snoop_match_o=0.
REQ-033 Two entries held, then reset_i pulsed low between clock edges -> v_o=0 and empty_o=1 immediately; no retire occurs after release.
